// File: rtl/byte_pair_packer_if.sv
// Byte-stream input and FIFO write-port bundle for the byte pair packer.
// The packer connects through the slave modport; the feeder/FIFO side uses master.
interface byte_pair_packer_if #(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 16
);
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_valid;
   logic                 in_sof;
   logic                 fifo_wrfull;
   logic [OUT_WIDTH-1:0] fifo_data;
   logic                 fifo_wrreq;

   // in_valid has no ready: every valid byte is taken while the block is enabled.
   // fifo_wrreq is a one-cycle strobe, raised only when fifo_wrfull was low at word completion.
   modport master (
      output in_data, in_valid, in_sof, fifo_wrfull,
      input  fifo_data, fifo_wrreq
   );

   modport slave (
      input  in_data, in_valid, in_sof, fifo_wrfull,
      output fifo_data, fifo_wrreq
   );
endinterface

// File: rtl/byte_pair_packer.sv
// Packs a byte stream MSB-first into 16-bit words for a dual-clock FIFO write port,
// flushing padded half-words on idle timeout or frame start, with drop/frame statistics.
module byte_pair_packer #(
   parameter int IN_WIDTH      = 8,
   parameter int OUT_WIDTH     = 16,
   parameter int FLUSH_TIMEOUT = 1024,
   parameter int PAD_VALUE     = 0,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   byte_pair_packer_if.slave    bus,
   output logic                 pending,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] drop_count
);
   localparam int TW = (FLUSH_TIMEOUT > 2) ? $clog2(FLUSH_TIMEOUT) : 1;
   localparam logic [TW-1:0]       TIMER_LAST = TW'(FLUSH_TIMEOUT - 1);
   localparam logic [IN_WIDTH-1:0] PAD        = IN_WIDTH'(PAD_VALUE);

   typedef enum logic {S_EMPTY, S_HALF} state_t;

   state_t                 state_q, state_d;
   logic [IN_WIDTH-1:0]    hold_q, hold_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic [OUT_WIDTH-1:0]   data_q, data_d;
   logic                   wrreq_q, wrreq_d;
   logic [CNT_WIDTH-1:0]   frame_q, frame_d;
   logic [CNT_WIDTH-1:0]   drop_q, drop_d;
   logic                   complete;
   logic [OUT_WIDTH-1:0]   word;
   logic                   accept;

   assign accept = enable & bus.in_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_EMPTY;
         hold_q  <= '0;
         timer_q <= '0;
         data_q  <= '0;
         wrreq_q <= 1'b0;
         frame_q <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         timer_q <= timer_d;
         data_q  <= data_d;
         wrreq_q <= wrreq_d;
         frame_q <= frame_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      timer_d  = timer_q;
      data_d   = data_q;
      wrreq_d  = 1'b0;
      frame_d  = frame_q;
      drop_d   = drop_q;
      complete = 1'b0;
      word     = '0;

      if (!enable) begin
         state_d = S_EMPTY;
         timer_d = '0;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  hold_d  = bus.in_data;
                  timer_d = '0;
                  state_d = S_HALF;
               end
            end
            S_HALF: begin
               // An arriving byte takes priority over an expiring timer.
               if (accept) begin
                  complete = 1'b1;
                  timer_d  = '0;
                  if (bus.in_sof) begin
                     word   = {hold_q, PAD};
                     hold_d = bus.in_data;
                  end else begin
                     word    = {hold_q, bus.in_data};
                     state_d = S_EMPTY;
                  end
               end else if (timer_q == TIMER_LAST) begin
                  complete = 1'b1;
                  word     = {hold_q, PAD};
                  timer_d  = '0;
                  state_d  = S_EMPTY;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end

      if (complete) begin
         if (bus.fifo_wrfull) begin
            if (drop_q != '1) drop_d = drop_q + CNT_WIDTH'(1);
         end else begin
            data_d  = word;
            wrreq_d = 1'b1;
         end
      end

      if (accept && bus.in_sof && (frame_q != '1)) frame_d = frame_q + CNT_WIDTH'(1);
   end

   assign bus.fifo_data  = data_q;
   assign bus.fifo_wrreq = wrreq_q;
   assign pending        = (state_q == S_HALF);
   assign frame_count    = frame_q;
   assign drop_count     = drop_q;
endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer: a per-cycle vector table for the basic packing
// paths, then hand-written sequences for timeout, saturation, enable and reset aborts.
module tb_byte_pair_packer;
   localparam int FT = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          pending;
   logic [CW-1:0] frame_count;
   logic [CW-1:0] drop_count;

   int n_checks = 0;
   int n_pass   = 0;

   byte_pair_packer_if #(.IN_WIDTH(8), .OUT_WIDTH(16)) bus ();

   byte_pair_packer #(
      .IN_WIDTH(8), .OUT_WIDTH(16), .FLUSH_TIMEOUT(FT), .PAD_VALUE(0), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .bus(bus),
      .pending(pending), .frame_count(frame_count), .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en, valid, sof;
      logic [7:0]  data;
      logic        full;
      logic        exp_wr;
      logic [15:0] exp_data;
      logic        exp_pend;
      logic [3:0]  exp_frame, exp_drop;
   } vec_t;

   vec_t vecs[9];

   function automatic vec_t mk(logic en, logic valid, logic sof, logic [7:0] data, logic full,
                               logic exp_wr, logic [15:0] exp_data, logic exp_pend,
                               logic [3:0] exp_frame, logic [3:0] exp_drop);
      vec_t v;
      v.en = en; v.valid = valid; v.sof = sof; v.data = data; v.full = full;
      v.exp_wr = exp_wr; v.exp_data = exp_data; v.exp_pend = exp_pend;
      v.exp_frame = exp_frame; v.exp_drop = exp_drop;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic drive(input logic en, input logic valid, input logic sof,
                        input logic [7:0] data, input logic full);
      enable              = en;
      bus.in_valid        = valid;
      bus.in_sof          = sof;
      bus.in_data         = data;
      bus.fifo_wrfull     = full;
   endtask

   // One clock edge, then settle before sampling outputs.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wr_seen;
      int wr_at;
      logic [15:0] wr_data;

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      #1;
      chk("reset_wrreq",   32'(bus.fifo_wrreq), 32'd0);
      chk("reset_data",    32'(bus.fifo_data),  32'd0);
      chk("reset_pending", 32'(pending),        32'd0);
      chk("reset_frame",   32'(frame_count),    32'd0);
      chk("reset_drop",    32'(drop_count),     32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #4;

      // en valid sof data full | wr data pend frame drop (outputs after the consuming edge)
      vecs[0] = mk(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 16'h0000, 1'b1, 4'd1, 4'd0);
      vecs[1] = mk(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 16'hA53C, 1'b0, 4'd1, 4'd0);
      vecs[2] = mk(1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 16'hA53C, 1'b1, 4'd2, 4'd0);
      vecs[3] = mk(1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 16'h1100, 1'b1, 4'd3, 4'd0);
      vecs[4] = mk(1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 1'b1, 16'h2233, 1'b0, 4'd3, 4'd0);
      vecs[5] = mk(1'b1, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 16'h2233, 1'b1, 4'd4, 4'd0);
      vecs[6] = mk(1'b1, 1'b1, 1'b0, 8'h66, 1'b1, 1'b0, 16'h2233, 1'b0, 4'd4, 4'd1);
      vecs[7] = mk(1'b1, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 16'h2233, 1'b1, 4'd4, 4'd1);
      vecs[8] = mk(1'b1, 1'b1, 1'b0, 8'h88, 1'b0, 1'b1, 16'h7788, 1'b0, 4'd4, 4'd1);

      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].en, vecs[i].valid, vecs[i].sof, vecs[i].data, vecs[i].full);
         cyc();
         chk($sformatf("vec%0d_wrreq", i),   32'(bus.fifo_wrreq), 32'(vecs[i].exp_wr));
         chk($sformatf("vec%0d_data", i),    32'(bus.fifo_data),  32'(vecs[i].exp_data));
         chk($sformatf("vec%0d_pending", i), 32'(pending),        32'(vecs[i].exp_pend));
         chk($sformatf("vec%0d_frame", i),   32'(frame_count),    32'(vecs[i].exp_frame));
         chk($sformatf("vec%0d_drop", i),    32'(drop_count),     32'(vecs[i].exp_drop));
      end

      // Idle flush: one byte, then 20 idle cycles; the padded write lands FT edges later.
      drive(1'b1, 1'b1, 1'b0, 8'h12, 1'b0);
      cyc();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      wr_seen = 0; wr_at = -1; wr_data = '0;
      for (int i = 1; i <= 20; i++) begin
         cyc();
         if (bus.fifo_wrreq) begin
            wr_seen++;
            wr_at   = i;
            wr_data = bus.fifo_data;
         end
      end
      chk("flush_count", 32'(wr_seen), 32'd1);
      chk("flush_edge",  32'(wr_at),   32'(FT));
      chk("flush_data",  32'(wr_data), 32'h1200);
      chk("flush_pend",  32'(pending), 32'd0);

      // A byte arriving in the expiry cycle completes normally instead of flushing.
      drive(1'b1, 1'b1, 1'b0, 8'h40, 1'b0);
      cyc();
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      wr_seen = 0;
      for (int i = 1; i < FT; i++) begin
         cyc();
         if (bus.fifo_wrreq) wr_seen++;
      end
      chk("expiry_no_early_wr", 32'(wr_seen), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 8'h41, 1'b0);
      cyc();
      chk("expiry_wrreq", 32'(bus.fifo_wrreq), 32'd1);
      chk("expiry_data",  32'(bus.fifo_data),  32'h4041);
      chk("expiry_pend",  32'(pending),        32'd0);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc();
      chk("expiry_one_pulse", 32'(bus.fifo_wrreq), 32'd0);

      // Drop saturation: 20 pairs against a full FIFO.
      wr_seen = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b0, 8'(i), 1'b1);
         cyc();
         if (bus.fifo_wrreq) wr_seen++;
         drive(1'b1, 1'b1, 1'b0, 8'(i + 100), 1'b1);
         cyc();
         if (bus.fifo_wrreq) wr_seen++;
      end
      chk("sat_drop",     32'(drop_count),    32'd15);
      chk("sat_no_wr",    32'(wr_seen),       32'd0);
      chk("sat_data_hold", 32'(bus.fifo_data), 32'h4041);

      // Back-to-back SOF bytes: one padded word per cycle, frame counter saturates.
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 1'b1, 1'b1, 8'(8'h60 + i), 1'b0);
         cyc();
         if (i > 0) begin
            chk($sformatf("sof_burst%0d_wrreq", i), 32'(bus.fifo_wrreq), 32'd1);
            chk($sformatf("sof_burst%0d_data", i),  32'(bus.fifo_data),  32'({8'(8'h60 + i - 1), 8'h00}));
         end
      end
      chk("sat_frame", 32'(frame_count), 32'd15);

      // Enable low while a half-word is held: discarded without a write.
      drive(1'b0, 1'b1, 1'b0, 8'hAA, 1'b0);
      cyc();
      chk("en_clear_pend", 32'(pending), 32'd0);
      drive(1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
      cyc();
      chk("en_held_pend", 32'(pending), 32'd1);
      drive(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0);
      cyc();
      chk("en_abort_pend",  32'(pending),        32'd0);
      chk("en_abort_wrreq", 32'(bus.fifo_wrreq), 32'd0);
      chk("en_frame_hold",  32'(frame_count),    32'd15);
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      wr_seen = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         cyc();
         if (bus.fifo_wrreq) wr_seen++;
      end
      chk("en_abort_no_flush", 32'(wr_seen), 32'd0);

      // Asynchronous reset mid-word, just after a write was registered.
      drive(1'b1, 1'b1, 1'b0, 8'hC1, 1'b0);
      cyc();
      drive(1'b1, 1'b1, 1'b0, 8'hC2, 1'b0);
      cyc();
      chk("pre_rst_wrreq", 32'(bus.fifo_wrreq), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 8'h99, 1'b0);
      cyc();
      chk("pre_rst_pend", 32'(pending), 32'd1);
      drive(1'b1, 1'b1, 1'b0, 8'hD1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_pend",  32'(pending),        32'd0);
      chk("rst_wrreq", 32'(bus.fifo_wrreq), 32'd0);
      chk("rst_data",  32'(bus.fifo_data),  32'd0);
      chk("rst_frame", 32'(frame_count),    32'd0);
      chk("rst_drop",  32'(drop_count),     32'd0);
      @(negedge clk);
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      wr_seen = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         cyc();
         if (bus.fifo_wrreq) wr_seen++;
      end
      chk("post_rst_no_wr", 32'(wr_seen), 32'd0);
      chk("post_rst_pend",  32'(pending), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/byte_pair_packer.md
Name: byte_pair_packer

Overview:
- Write-side feeder for the dual-clock FIFO Avalon bridge. Runs in the FIFO write-clock domain.
- Accepts a byte stream with start-of-frame marking and packs byte pairs MSB-first into 16-bit words.
- Drives the FIFO write port (data/wrreq) and respects wrfull, dropping and counting words when the FIFO is full.
- Flushes a pending half-word on idle timeout or new frame start, and keeps frame/drop statistics.

Parameters:
- IN_WIDTH, 8, input byte width.
- OUT_WIDTH, 16, FIFO word width; must equal 2*IN_WIDTH.
- FLUSH_TIMEOUT, 1024, idle cycles with a pending half-word before a padded flush; must be >= 2.
- PAD_VALUE, 0, value placed in the low half of a flushed word.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock (FIFO write clock).
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  block enable; low = idle and discard pending data.
- in_data  in  IN_WIDTH  input byte.
- in_valid  in  1  in_data valid this cycle (no backpressure; always accepted when enable=1).
- in_sof  in  1  qualifies in_valid: this byte starts a new frame.
- fifo_wrfull  in  1  FIFO write-side full flag.
- fifo_data  out  OUT_WIDTH  word to FIFO.
- fifo_wrreq  out  1  one-cycle write strobe.
- pending  out  1  high while a half-word is held.
- frame_count  out  CNT_WIDTH  number of accepted SOF bytes, saturating.
- drop_count  out  CNT_WIDTH  number of words dropped due to full, saturating.

Behaviour:
- Reset: all outputs 0, state EMPTY, timer 0, holding register 0.
- State machine:
  - EMPTY: on accepted byte B, hold B in the upper half and go to HALF.
  - HALF: on accepted byte B with in_sof=0, complete word {held, B} and go to EMPTY.
  - HALF: on accepted byte B with in_sof=1, complete padded word {held, PAD_VALUE}, hold B, stay in HALF.
  - HALF: when the timer reaches FLUSH_TIMEOUT-1 with no byte, complete padded word {held, PAD_VALUE} and go to EMPTY.
- Timer: cleared on entry to HALF and on every accepted byte; increments each idle cycle in HALF.
- An accepted byte in the expiry cycle wins: normal completion, no flush.
- Word completion in cycle N:
  - fifo_wrfull sampled in cycle N.
  - If wrfull=0: fifo_data is registered and fifo_wrreq=1 in cycle N+1 only (latency 1).
  - If wrfull=1: word discarded, fifo_wrreq stays 0, drop_count increments in N+1.
- Maximum write rate is one word per 2 input bytes, or one word per cycle when SOF bytes arrive back to back.
- fifo_data holds its last value when fifo_wrreq=0.
- frame_count increments for each byte with in_valid & in_sof & enable.
- Both counters saturate at all-ones and never wrap.
- enable=0:
  - in_valid ignored; state forced to EMPTY; pending half discarded with no write.
  - Timer cleared; counters hold.
  - A word completed in the previous cycle still emits its wrreq.
- pending = (state == HALF).
- Reset mid-operation drops any pending half and any registered-but-unissued write immediately; no wrreq after reset assertion.

Test Plan:
- Normal pair: enable=1; bytes 0xA5 (sof=1) then 0x3C on consecutive cycles; wrfull=0 -> one wrreq pulse the cycle after 0x3C, fifo_data=0xA53C; frame_count=1; pending=0.
- Idle flush: FLUSH_TIMEOUT=8; single byte 0x12 then 20 idle cycles -> exactly one wrreq with fifo_data=0x1200, 8 cycles after the byte; no further writes.
- SOF mid-word: byte 0x11 (sof=1), then 0x22 (sof=1), then 0x33 -> words 0x1100 then 0x2233; frame_count=2.
- Full drop: wrfull=1 during completion of 0x5566 -> no wrreq, drop_count=1; next pair 0x7788 with wrfull=0 -> written.
- Saturation: CNT_WIDTH=4; force 20 drops -> drop_count stays at 15.
- Enable/reset abort: byte 0x99 held; enable low one cycle -> pending=0, no write. Repeat with async reset pulse mid-word -> all outputs 0 immediately, no wrreq afterwards.
